xor_frame_checker: RTL and testbench
====================================

# xor_frame_checker

Receive-side checker for XOR-checksummed 32-bit word frames on the core's internal streaming paths. It consumes a frame made of a header word, N payload words and a trailing checksum word. Payload words are forwarded through a one-entry output buffer, the checksum is recomputed on the fly, and one result record per frame reports pass/fail and framing errors. It is the reader counterpart of the XOR-checksum generator used on the write side.

## Interface
- DATA_W, 32, word width
- LEN_W, 8, width of the payload-length field, taken from header bits [LEN_W-1:0]
- SEED, 32'h0000_0000, initial checksum accumulator value
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset: synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_data  in  DATA_W  header, payload or checksum word
- in_last  in  1  marks the final word of a frame; legal only on the checksum word
- out_valid / out_ready  out / in  1 / 1  payload output handshake
- out_data  out  DATA_W  forwarded payload word
- out_last  out  1  final forwarded payload word of the frame
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_ok  out  1  checksum matched and framing was correct
- res_err_len  out  1  in_last arrived early, or did not arrive on the checksum word
- res_sum  out  DATA_W  computed checksum (SEED ^ header ^ all accepted payload words)

## Operation
- States: HDR, PAY, CHK, DRAIN, RES. Reset state is HDR.
- Reset values: acc = SEED, cnt = 0, every output valid/flag = 0, data outputs = 0.
- HDR
  - Accept one word: cnt <= in_data[LEN_W-1:0] and acc <= SEED ^ in_data.
  - If in_last=1: record err_len=1, go to RES.
  - Else if cnt==0: go to CHK. Else go to PAY.
- PAY
  - Each accepted word is loaded into the output buffer; acc ^= word and cnt decrements.
  - out_last=1 when cnt==1 or when in_last=1.
  - If in_last=1: record err_len=1, go to RES.
  - Else if cnt==1: go to CHK.
- CHK
  - Accept one word and set ok = (in_data == acc) && in_last.
  - If in_last=1: go to RES with err_len=0.
  - If in_last=0: err_len=1, go to DRAIN.
- DRAIN: accept and discard words until one with in_last=1, then go to RES.
- RES
  - res_valid=1, fields held stable until res_ready=1.
  - On res_ready=1: return to HDR and reset acc to SEED.
  - res_ok is forced to 0 whenever res_err_len=1.
- in_ready
  - HDR, CHK, DRAIN: in_ready = 1.
  - PAY: in_ready = !out_valid || out_ready.
  - RES: in_ready = 0.
- Checksum arithmetic is XOR only; the count wraps modulo 2^LEN_W; N is at most 2^LEN_W-1.

## Timing
- A handshake completes when valid && ready are both high at a rising edge.
- Payload latency is 1 cycle: a word accepted at edge k gives out_valid=1 after edge k.
- Full throughput: the output buffer refills in the same cycle it drains, so 1 word/cycle while out_ready=1.
- res_valid rises on the edge that accepts the checksum word, or the edge that accepts the terminating early-last word.
- The next header can be accepted no earlier than the cycle after the res handshake.
- out_valid/out_data must not change while out_valid && !out_ready.
- The output buffer drains independently of the checker state; RES does not wait for it.
- rst asserted mid-frame: at the next edge, state returns to HDR, the buffered word and pending result are dropped, and all valids go to 0.

## Structure
- Shared package xor_frame_pkg holds:
  - state enum {HDR, PAY, CHK, DRAIN, RES}
  - DATA_W/LEN_W defaults
  - result-record struct {ok, err_len, sum}
- One sub-module: stream_out_reg, the one-entry output buffer with its valid/ready handshake. The generator side reuses it.

## Test plan
- SEED=0; header 0x0000_0002, payload 0x1111_1111, 0x2222_2222, checksum 0x3333_3331 with in_last -> both words out, out_last on the second word; res_ok=1, res_err_len=0, res_sum=0x3333_3331.
- Same frame with checksum 0x3333_3330 -> res_ok=0, res_err_len=0, res_sum=0x3333_3331.
- Header 0x0000_0000, then checksum 0x0000_0000 with in_last -> no out_valid; res_ok=1.
- Header N=3, in_last set on the 2nd payload word -> 2 words out, out_last on the 2nd; res_err_len=1, res_ok=0.
- N=4 frame with out_ready low for 5 cycles mid-payload -> in_ready low while the buffer is full, out_data held stable, no word lost or duplicated; res_ok=1.
- rst pulsed for 1 cycle during PAY -> next cycle out_valid=0 and res_valid=0; a fresh valid frame afterwards gives res_ok=1.

Source files
------------

// File: rtl/xor_frame_pkg.sv
// Shared types for the XOR-checksummed frame checker and its generator counterpart.
package xor_frame_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [2:0] {
      HDR,
      PAY,
      CHK,
      DRAIN,
      RES
   } state_t;

   typedef struct packed {
      logic                  ok;
      logic                  err_len;
      logic [DEF_DATA_W-1:0] sum;
   } result_t;

endpackage

// File: rtl/xor_frame_checker_if.sv
// Frame input, payload output and result handshakes of the frame checker.
interface xor_frame_checker_if
   import xor_frame_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              res_valid;
   logic              res_ready;
   logic              res_ok;
   logic              res_err_len;
   logic [DATA_W-1:0] res_sum;

   modport master (
      output in_valid, in_data, in_last, out_ready, res_ready,
      input  in_ready, out_valid, out_data, out_last,
             res_valid, res_ok, res_err_len, res_sum
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready, res_ready,
      output in_ready, out_valid, out_data, out_last,
             res_valid, res_ok, res_err_len, res_sum
   );

endinterface

// File: rtl/xor_frame_checker_stream_out_reg.sv
// One-entry output buffer; accepts a new word in the same cycle the held one drains.
module stream_out_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   logic              valid_reg;
   logic [DATA_W-1:0] data_reg;
   logic              last_reg;

   assign load_ready = !valid_reg || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         last_reg  <= 1'b0;
      end else if (load_valid && load_ready) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
         last_reg  <= load_last;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid = valid_reg;
   assign out_data  = data_reg;
   assign out_last  = last_reg;

endmodule

// File: rtl/xor_frame_checker.sv
// Receive-side checker: forwards payload, recomputes the XOR checksum, reports one result per frame.
module xor_frame_checker
   import xor_frame_pkg::*;
#(
   parameter int                DATA_W = DEF_DATA_W,
   parameter int                LEN_W  = DEF_LEN_W,
   parameter logic [DATA_W-1:0] SEED   = '0
) (
   input logic                clk,
   input logic                rst,
   xor_frame_checker_if.slave bus
);

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] acc_reg;
   logic [LEN_W-1:0]  cnt_reg;
   result_t           res_reg;

   logic             in_ready;
   logic             res_valid;
   logic             buf_ready;
   logic             in_fire;
   logic [LEN_W-1:0] hdr_len;
   logic             cnt_one;

   assign in_fire = bus.in_valid && in_ready;
   assign hdr_len = bus.in_data[LEN_W-1:0];
   assign cnt_one = (cnt_reg == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= HDR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HDR: begin
            if (in_fire) begin
               if (bus.in_last)          state_next = RES;
               else if (hdr_len == '0)   state_next = CHK;
               else                      state_next = PAY;
            end
         end
         PAY: begin
            if (in_fire) begin
               if (bus.in_last)          state_next = RES;
               else if (cnt_one)         state_next = CHK;
            end
         end
         CHK: begin
            if (in_fire) state_next = bus.in_last ? RES : DRAIN;
         end
         DRAIN: begin
            if (in_fire && bus.in_last) state_next = RES;
         end
         RES: begin
            if (bus.res_ready) state_next = HDR;
         end
         default: state_next = HDR;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state_reg)
         HDR, CHK, DRAIN: in_ready  = 1'b1;
         PAY:             in_ready  = buf_ready;
         RES:             res_valid = 1'b1;
         default:         in_ready  = 1'b0;
      endcase
   end

   // Early-terminated frames capture the running sum including the terminating word.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg <= SEED;
         cnt_reg <= '0;
         res_reg <= '0;
      end else begin
         case (state_reg)
            HDR: begin
               if (in_fire) begin
                  acc_reg <= SEED ^ bus.in_data;
                  cnt_reg <= hdr_len;
                  if (bus.in_last) begin
                     res_reg <= '{ok: 1'b0, err_len: 1'b1, sum: SEED ^ bus.in_data};
                  end
               end
            end
            PAY: begin
               if (in_fire) begin
                  acc_reg <= acc_reg ^ bus.in_data;
                  cnt_reg <= cnt_reg - LEN_W'(1);
                  if (bus.in_last) begin
                     res_reg <= '{ok: 1'b0, err_len: 1'b1, sum: acc_reg ^ bus.in_data};
                  end
               end
            end
            CHK: begin
               if (in_fire) begin
                  res_reg <= '{ok:      (bus.in_data == acc_reg) && bus.in_last,
                               err_len: !bus.in_last,
                               sum:     acc_reg};
               end
            end
            RES: begin
               if (bus.res_ready) acc_reg <= SEED;
            end
            default: ;
         endcase
      end
   end

   stream_out_reg #(
      .DATA_W (DATA_W)
   ) u_out (
      .clk        (clk),
      .rst        (rst),
      .load_valid ((state_reg == PAY) && bus.in_valid),
      .load_data  (bus.in_data),
      .load_last  (cnt_one || bus.in_last),
      .load_ready (buf_ready),
      .out_valid  (bus.out_valid),
      .out_data   (bus.out_data),
      .out_last   (bus.out_last),
      .out_ready  (bus.out_ready)
   );

   assign bus.in_ready    = in_ready;
   assign bus.res_valid   = res_valid;
   assign bus.res_ok      = res_reg.ok && !res_reg.err_len;
   assign bus.res_err_len = res_reg.err_len;
   assign bus.res_sum     = res_reg.sum;

endmodule

// File: tb/tb_xor_frame_checker.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_xor_frame_checker;

   localparam logic [31:0] SEED = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xor_frame_checker_if #(.DATA_W(32)) bus ();

   xor_frame_checker #(
      .DATA_W (32),
      .LEN_W  (8),
      .SEED   (SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total  = 0;
   int passed = 0;

   int cyc        = 0;
   int stall_from = -1;
   int stall_to   = -1;
   bit rand_mode  = 1'b0;
   bit pay_phase  = 1'b0;

   logic [31:0] got_d[$];
   logic        got_l[$];
   int          res_cnt = 0;
   logic        got_ok, got_err;
   logic [31:0] got_sum;
   int          stab_err = 0;
   int          inr_err  = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] hold_data = '0;
   logic        hold_last = 1'b0;

   logic [31:0] fw[$];
   logic        fl[$];
   logic [31:0] exp_d[$];
   logic        exp_l[$];
   logic        exp_ok, exp_err;
   logic [31:0] exp_sum;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Ready driver: optional stall window, otherwise random or always-ready.
   initial begin
      bus.out_ready = 1'b1;
      bus.res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc >= stall_from && cyc < stall_to) bus.out_ready = 1'b0;
         else if (rand_mode)                      bus.out_ready = ($urandom_range(0, 3) != 0);
         else                                     bus.out_ready = 1'b1;
         bus.res_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && (bus.out_valid !== 1'b1 || bus.out_data !== hold_data ||
                           bus.out_last !== hold_last)) stab_err++;
         if (bus.out_valid && !bus.out_ready && bus.in_valid && bus.in_ready && pay_phase) inr_err++;
         if (bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
         end
         if (bus.res_valid && bus.res_ready) begin
            res_cnt++;
            got_ok  = bus.res_ok;
            got_err = bus.res_err_len;
            got_sum = bus.res_sum;
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
         hold_last = bus.out_last;
      end
   end

   // Frame-level model: walk header, N payload words, then the checksum word.
   task automatic model();
      logic [31:0] acc;
      int n, i;
      exp_d.delete();
      exp_l.delete();
      acc     = SEED ^ fw[0];
      n       = int'(fw[0][7:0]);
      exp_ok  = 1'b0;
      exp_err = 1'b1;
      exp_sum = acc;
      if (fl[0]) return;
      i = 1;
      for (int k = 0; k < n; k++) begin
         acc ^= fw[i];
         exp_d.push_back(fw[i]);
         exp_l.push_back((k == n - 1) || fl[i]);
         if (fl[i]) begin
            exp_sum = acc;
            return;
         end
         i++;
      end
      exp_sum = acc;
      exp_err = !fl[i];
      exp_ok  = fl[i] && (fw[i] == acc);
   endtask

   // kind: 0 good, 1 bad checksum, 2 early last, 3 last on header, 4 missing last (drain)
   task automatic gen_frame(input int kind, input int n);
      logic [31:0] hdr, acc, w;
      int cut;
      fw.delete();
      fl.delete();
      hdr = ($urandom & 32'hFFFF_FF00) | 32'(n);
      fw.push_back(hdr);
      fl.push_back(kind == 3);
      if (kind == 3) return;
      acc = SEED ^ hdr;
      cut = (n > 0) ? $urandom_range(0, n - 1) : 0;
      for (int k = 0; k < n; k++) begin
         w = $urandom;
         acc ^= w;
         fw.push_back(w);
         fl.push_back(kind == 2 && k == cut);
         if (kind == 2 && k == cut) return;
      end
      fw.push_back((kind == 1) ? (acc ^ (32'h1 << $urandom_range(0, 31))) : acc);
      if (kind == 4) begin
         fl.push_back(1'b0);
         cut = $urandom_range(1, 3);
         for (int k = 0; k < cut; k++) begin
            fw.push_back($urandom);
            fl.push_back(k == cut - 1);
         end
      end else begin
         fl.push_back(1'b1);
      end
   endtask

   task automatic send_word(input string tag, input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = (bus.in_ready === 1'b1);
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      check({tag, "_accept"}, 32'(ok), 32'd1);
   endtask

   task automatic run_frame(input string tag, input bit idle_rand);
      int base_out, base_res, waitc, nout;
      model();
      base_out = got_d.size();
      base_res = res_cnt;
      for (int i = 0; i < fw.size(); i++) begin
         if (idle_rand) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         pay_phase = (i >= 1 && i <= exp_d.size());
         send_word(tag, fw[i], fl[i]);
         if (pay_phase) begin
            check({tag, "_pay_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_pay_data"}, bus.out_data, fw[i]);
         end
      end
      pay_phase = 1'b0;
      check({tag, "_res_valid_rise"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_in_ready_res"}, 32'(bus.in_ready), 32'd0);
      waitc = 0;
      while (res_cnt == base_res && waitc < 200) begin
         @(posedge clk);
         #1;
         waitc++;
      end
      check({tag, "_res_handshakes"}, 32'(res_cnt - base_res), 32'd1);
      while (bus.out_valid && waitc < 400) begin
         @(posedge clk);
         #1;
         waitc++;
      end
      check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_res_ok"}, 32'(got_ok), 32'(exp_ok));
      check({tag, "_res_err_len"}, 32'(got_err), 32'(exp_err));
      check({tag, "_res_sum"}, got_sum, exp_sum);
      nout = got_d.size() - base_out;
      check({tag, "_out_count"}, 32'(nout), 32'(exp_d.size()));
      for (int k = 0; k < nout && k < exp_d.size(); k++) begin
         check({tag, "_out_data"}, got_d[base_out + k], exp_d[k]);
         check({tag, "_out_last"}, 32'(got_l[base_out + k]), 32'(exp_l[k]));
      end
      $display("frame %s: hdr=%h words=%0d out=%0d ok=%0d err_len=%0d sum=%h",
               tag, fw[0], fw.size(), nout, got_ok, got_err, got_sum);
   endtask

   initial begin
      int kind, n, base_stab, base_inr;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_res_ok", 32'(bus.res_ok), 32'd0);
      check("rst_res_err", 32'(bus.res_err_len), 32'd0);
      check("rst_res_sum", bus.res_sum, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      fw = '{32'h0000_0002, 32'h1111_1111, 32'h2222_2222, 32'h3333_3331};
      fl = '{1'b0, 1'b0, 1'b0, 1'b1};
      run_frame("good2", 1'b0);
      fw[3] = 32'h3333_3330;
      run_frame("badsum", 1'b0);
      fw = '{32'h0000_0000, 32'h0000_0000};
      fl = '{1'b0, 1'b1};
      run_frame("empty", 1'b0);
      fw = '{32'h0000_0003, 32'hA5A5_0001, 32'h5A5A_0002};
      fl = '{1'b0, 1'b0, 1'b1};
      run_frame("early", 1'b0);

      base_stab = stab_err;
      base_inr  = inr_err;
      gen_frame(0, 4);
      stall_from = cyc + 3;
      stall_to   = stall_from + 5;
      run_frame("stall4", 1'b0);
      check("stall_hold_stable", 32'(stab_err - base_stab), 32'd0);
      check("stall_in_ready_low", 32'(inr_err - base_inr), 32'd0);

      gen_frame(0, 3);
      stall_from = cyc;
      stall_to   = cyc + 10;
      send_word("rstpay", fw[0], fl[0]);
      send_word("rstpay", fw[1], fl[1]);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      gen_frame(0, 2);
      run_frame("after_rst", 1'b0);

      rand_mode = 1'b1;
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 5);
         n    = $urandom_range(0, 6);
         if (kind == 5) begin
            kind = 0;
            n    = 0;
         end
         if (kind == 2 && n == 0) n = 1;
         gen_frame(kind, n);
         run_frame($sformatf("rnd%0d_k%0d", f, kind), 1'b1);
      end

      check("final_hold_stable", 32'(stab_err), 32'd0);
      check("final_in_ready_stall", 32'(inr_err), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
